// File: rtl/si_div_iter_12b_pkg.sv
// Shared constants and state encoding for the iterative signed divider.
// Default operand width, iteration count and FSM states.
package si_div_iter_12b_pkg;

    localparam int DW_DEF = 12;
    localparam int ITER   = 2 * DW_DEF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/si_div_step.sv
// One restoring shift-subtract iteration of the magnitude divider.
// Produces the next partial remainder and one quotient bit.
module si_div_step
    import si_div_iter_12b_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0] prem,
    input  logic        din,
    input  logic [DW:0] dvs,
    output logic [DW:0] nrem,
    output logic        qbit
);

    logic [DW+1:0] trial;
    logic [DW+1:0] diff;

    // prem < dvs <= 2^(DW-1), so trial never reaches bit DW+1
    assign trial = {prem, din};
    assign diff  = trial - {1'b0, dvs};
    assign qbit  = ~diff[DW+1];
    assign nrem  = qbit ? diff[DW:0] : trial[DW:0];

endmodule

// File: rtl/si_div_iter_12b.sv
// Iterative signed divider: 2*DW-bit dividend by DW-bit divisor,
// truncating toward zero, with saturation and divide-by-zero flags.
module si_div_iter_12b
    import si_div_iter_12b_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] dvd,
    input  logic [DW-1:0]   dvs,
    input  logic            in_vld,
    output logic            in_rdy,
    output logic [DW-1:0]   quo,
    output logic [DW-1:0]   rem,
    output logic            div0,
    output logic            ovf,
    output logic            out_vld,
    input  logic            out_rdy
);

    localparam int CW = $clog2(2 * DW + 1);
    localparam logic [CW-1:0] NIT = CW'(2 * DW);

    localparam logic [2*DW-1:0] QPOS = {{(DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [2*DW-1:0] QNEG = {{DW{1'b0}}, 1'b1, {(DW - 1){1'b0}}};
    localparam logic [DW-1:0]   SMAX = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0]   SMIN = {1'b1, {(DW - 1){1'b0}}};

    state_t st, st_n;

    logic            sd, ss;
    logic [2*DW-1:0] acc;
    logic [DW:0]     mdvs, prem, prem_n;
    logic            qbit;
    logic [CW-1:0]   cnt;

    logic            dz;
    logic [2*DW-1:0] advd;
    logic [DW:0]     advs;
    logic            neg, ovf_n;
    logic [DW-1:0]   qs, quo_n, rem_n;

    assign dz   = (dvs == '0);
    assign advd = dvd[2*DW-1] ? -dvd : dvd;
    // One extra bit so the most negative divisor has a magnitude
    assign advs = dvs[DW-1] ? -{1'b1, dvs} : {1'b0, dvs};

    si_div_step #(.DW(DW)) u_step (
        .prem (prem),
        .din  (acc[2*DW-1]),
        .dvs  (mdvs),
        .nrem (prem_n),
        .qbit (qbit)
    );

    assign neg   = sd ^ ss;
    assign ovf_n = neg ? (acc > QNEG) : (acc > QPOS);
    assign qs    = neg ? -acc[DW-1:0] : acc[DW-1:0];
    assign quo_n = ovf_n ? (neg ? SMIN : SMAX) : qs;
    assign rem_n = sd ? -prem[DW-1:0] : prem[DW-1:0];

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE: if (in_vld) st_n = dz ? DONE : CALC;
            CALC: if (cnt == CW'(1)) st_n = FIX;
            FIX:  st_n = DONE;
            DONE: if (out_rdy) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    assign in_rdy  = (st == IDLE);
    assign out_vld = (st == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st   <= IDLE;
            cnt  <= '0;
            sd   <= 1'b0;
            ss   <= 1'b0;
            acc  <= '0;
            mdvs <= '0;
            prem <= '0;
            quo  <= '0;
            rem  <= '0;
            div0 <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            st <= st_n;
            unique case (st)
                IDLE: begin
                    if (in_vld) begin
                        sd   <= dvd[2*DW-1];
                        ss   <= dvs[DW-1];
                        acc  <= advd;
                        mdvs <= advs;
                        prem <= '0;
                        cnt  <= NIT;
                        if (dz) begin
                            div0 <= 1'b1;
                            ovf  <= 1'b0;
                            rem  <= '0;
                            quo  <= dvd[2*DW-1] ? SMIN : SMAX;
                        end
                    end
                end
                CALC: begin
                    // Dividend bits shift out as quotient bits shift in
                    acc  <= {acc[2*DW-2:0], qbit};
                    prem <= prem_n;
                    cnt  <= cnt - CW'(1);
                end
                FIX: begin
                    quo  <= quo_n;
                    rem  <= rem_n;
                    ovf  <= ovf_n;
                    div0 <= 1'b0;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_si_div_iter_12b.sv
// Directed self-checking bench for si_div_iter_12b.
// Expected quotients/remainders are hand-derived constants.
module tb_si_div_iter_12b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] dvd = '0;
    logic [11:0] dvs = '0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic        in_rdy;
    logic [11:0] quo;
    logic [11:0] rem;
    logic        div0;
    logic        ovf;
    logic        out_vld;

    int vecs = 0;
    int errs = 0;

    si_div_iter_12b dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dvd     (dvd),
        .dvs     (dvs),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .quo     (quo),
        .rem     (rem),
        .div0    (div0),
        .ovf     (ovf),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    // Called at a negedge; issues one division and checks the result.
    task automatic run(input string nm, input int a, input int b,
                       input int eq, input int er,
                       input logic e0, input logic eo,
                       input int elat, input int hold);
        int n;
        logic [11:0] xq, xr;
        xq = 12'(eq);
        xr = 12'(er);
        vecs++;
        if (in_rdy !== 1'b1) begin
            errs++;
            $display("FAIL %s in_rdy got %b want 1", nm, in_rdy);
        end
        dvd = 24'(a);
        dvs = 12'(b);
        in_vld = 1'b1;
        @(negedge clk);
        // Garbage operands while busy must be ignored
        dvd = 24'h5a5a5;
        dvs = 12'h003;
        n = 1;
        vecs++;
        if (in_rdy !== 1'b0) begin
            errs++;
            $display("FAIL %s busy in_rdy got %b want 0", nm, in_rdy);
        end
        while (out_vld !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (n != elat) begin
            errs++;
            $display("FAIL %s latency got %0d want %0d", nm, n, elat);
        end
        vecs++;
        if (quo !== xq) begin
            errs++;
            $display("FAIL %s quo got %0d want %0d", nm,
                     $signed(quo), $signed(xq));
        end
        vecs++;
        if (rem !== xr) begin
            errs++;
            $display("FAIL %s rem got %0d want %0d", nm,
                     $signed(rem), $signed(xr));
        end
        vecs++;
        if ({div0, ovf} !== {e0, eo}) begin
            errs++;
            $display("FAIL %s div0/ovf got %b%b want %b%b",
                     nm, div0, ovf, e0, eo);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vecs++;
            if ({quo, rem, div0, ovf, out_vld, in_rdy} !==
                {xq, xr, e0, eo, 1'b1, 1'b0}) begin
                errs++;
                $display("FAIL %s hold%0d quo=%h rem=%h vld=%b rdy=%b",
                         nm, i, quo, rem, out_vld, in_rdy);
            end
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        vecs++;
        if ({out_vld, in_rdy} !== 2'b01) begin
            errs++;
            $display("FAIL %s accept vld/rdy got %b%b want 01",
                     nm, out_vld, in_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        out_rdy = 1'b0;
        vecs++;
        if ({in_rdy, out_vld, quo, rem, div0, ovf} !==
            {1'b1, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset rdy=%b vld=%b quo=%h rem=%h d0=%b ov=%b",
                     in_rdy, out_vld, quo, rem, div0, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run("pos_pos", 1000, 7, 142, 6, 1'b0, 1'b0, 26, 0);
        run("neg_pos", -1000, 7, -142, -6, 1'b0, 1'b0, 26, 0);
        run("pos_neg", 1000, -7, -142, 6, 1'b0, 1'b0, 26, 0);
        run("neg_neg", -1000, -7, 142, -6, 1'b0, 1'b0, 26, 0);
        run("zero_dvd", 0, -5, 0, 0, 1'b0, 1'b0, 26, 0);
    endtask

    task automatic test_ovf();
        run("ovf_max", 8388607, 1, 2047, 0, 1'b0, 1'b1, 26, 0);
        run("ovf_wrap", -4194304, 2048, 2047, 0, 1'b0, 1'b1, 26, 0);
        run("ovf_min", -8388608, 1, -2048, 0, 1'b0, 1'b1, 26, 0);
        run("min_ok", 4194304, -2048, -2048, 0, 1'b0, 1'b0, 26, 0);
    endtask

    task automatic test_div0();
        run("div0_pos", 5, 0, 2047, 0, 1'b1, 1'b0, 1, 2);
        run("div0_neg", -5, 0, -2048, 0, 1'b1, 1'b0, 1, 0);
        run("div0_zero", 0, 0, 2047, 0, 1'b1, 1'b0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int ta[5] = '{123, -2048, 2047, -7, 555};
        int tb[5] = '{-45, 2047, -2048, 3, 2};
        for (int i = 0; i < 5; i++) begin
            run("roundtrip", ta[i] * tb[i], tb[i], ta[i], 0,
                1'b0, 1'b0, 26, (i == 0) ? 10 : 0);
        end
    endtask

    task automatic test_reset_mid();
        vecs++;
        if (in_rdy !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid start in_rdy got %b want 1", in_rdy);
        end
        dvd = 24'(1000);
        dvs = 12'(7);
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vecs++;
        if ({in_rdy, out_vld, quo, div0} !==
            {1'b1, 1'b0, 12'h0, 1'b0}) begin
            errs++;
            $display("FAIL rst_mid rdy=%b vld=%b quo=%h d0=%b",
                     in_rdy, out_vld, quo, div0);
        end
        rst_n = 1'b1;
        run("after_rst", 1000, -7, -142, 6, 1'b0, 1'b0, 26, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_ovf();
        test_div0();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/si_div_iter_12b.md
SI_DIV_ITER_12B -- requirements
Module: si_div_iter_12b

Interface
REQ-001 SHALL have parameter: DW, 12, operand width; dividend is 2*DW bits, matching the signed multiplier product width.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: dvd  input  2*DW  signed dividend.
REQ-005 SHALL have port: dvs  input  DW  signed divisor.
REQ-006 SHALL have port: in_vld  input  1  operands valid.
REQ-007 SHALL have port: in_rdy  output  1  block can accept operands.
REQ-008 SHALL have port: quo  output  DW  signed quotient.
REQ-009 SHALL have port: rem  output  DW  signed remainder.
REQ-010 SHALL have port: div0  output  1  divisor was zero.
REQ-011 SHALL have port: ovf  output  1  quotient out of DW-bit signed range; quo saturated.
REQ-012 SHALL have port: out_vld  output  1  result valid.
REQ-013 SHALL have port: out_rdy  input  1  consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL assert in_rdy only in IDLE; operands are captured on a clock edge where in_vld && in_rdy.
REQ-016 On capture, SHALL register sign(dvd), sign(dvs), |dvd| (2*DW bits) and |dvs| (DW+1 bits, so -2^(DW-1) is representable).
REQ-017 On capture with dvs==0, SHALL go IDLE->DONE with div0=1, ovf=0, rem=0, quo=2^(DW-1)-1 if dvd>=0, else -2^(DW-1).
REQ-018 Otherwise IDLE->CALC; SHALL run exactly 2*DW restoring (non-performing) shift-subtract iterations, one quotient bit per cycle, MSB first, counted by a down-counter.
REQ-019 SHALL go CALC->FIX after the last iteration; FIX applies signs in one cycle: quotient negated if sign(dvd)^sign(dvs); remainder carries the sign of dvd (truncation toward zero).
REQ-020 In FIX, SHALL set ovf=1 when the signed quotient lies outside [-2^(DW-1), 2^(DW-1)-1], and saturate quo to the nearest bound; rem remains exact.
REQ-021 Latency: capture in cycle 0, out_vld high from cycle 2*DW+2 (26 for DW=12); for div0, out_vld high from cycle 1.
REQ-022 In DONE, SHALL hold out_vld=1 and quo/rem/div0/ovf stable until out_rdy=1; DONE->IDLE on that edge; in_rdy stays 0 throughout DONE.
REQ-023 SHALL hold quo, rem, div0 and ovf at their last values outside DONE; these values are only meaningful while out_vld=1.
REQ-024 SHALL ignore in_vld while not in IDLE; SHALL ignore out_rdy while not in DONE.
REQ-025 |remainder| < |dvs| <= 2^(DW-1) SHALL fit in DW signed bits without saturation.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, counter=0, in_rdy=1, out_vld=0, quo=0, rem=0, div0=0, ovf=0 from any state, including mid-CALC; the in-flight operation is discarded.
REQ-027 After reset release, the first capture SHALL be possible on the next edge with in_vld=1.

Structure
REQ-028 A shared package SHALL hold DW default, the FSM state enum, and ITER=2*DW.
REQ-029 One sub-module, si_div_step, SHALL implement one conditional-subtract iteration (partial remainder, divisor -> next partial remainder, quotient bit); it is combinational and instantiated once.

Verification
REQ-030 dvd=1000, dvs=7 -> after 26 cycles quo=142, rem=6, div0=0, ovf=0.
REQ-031 dvd=-1000, dvs=7 -> quo=-142, rem=-6; dvd=1000, dvs=-7 -> quo=-142, rem=6.
REQ-032 dvd=8388607, dvs=1 -> ovf=1, quo=2047; dvd=-4194304, dvs=2048 (sign-wrapped to -2048) -> quo=2048 out of range, ovf=1, quo=2047.
REQ-033 dvd=5, dvs=0 -> out_vld in cycle 1, div0=1, quo=2047, rem=0; dvd=-5, dvs=0 -> quo=-2048.
REQ-034 Round-trip: random a, b != 0, dvd=a*b, dvs=b -> quo=a, rem=0; with out_rdy held low 10 cycles, outputs stay stable and in_rdy stays 0.
REQ-035 rst_n pulsed low in CALC cycle 10 -> next cycle IDLE, out_vld=0, in_rdy=1; a new operand pair then completes correctly.
